// File: rtl/sfp_tx_link_ctrl.sv
// SFP TX link bring-up / fault sequencer: laser enable, settle, comma training, payload run.
// Optional blinking LEDs when SFP_TX_LINK_CTRL_LED_BLINK_EN is defined.
//
// state    | meaning
// OFF      | laser off, waiting for link enable with no fault
// LASER_ON | laser on, waiting STARTUP_CLKS for the optics to settle
// TRAIN    | driver on, K28.5 in every slot for TRAIN_SYMS strobes
// RUN      | payload allowed; STABLE_SYMS clean strobes clear the retry count
// FAULT    | laser off for RETRY_CLKS, then retry if the fault is gone
// LOCKOUT  | too many consecutive faults; waits for i_fault_clr
module sfp_tx_link_ctrl #(
   parameter logic [15:0] STARTUP_CLKS = 16'd6000,
   parameter logic [9:0]  TRAIN_SYMS   = 10'd512,
   parameter logic [7:0]  FLT_DEBOUNCE = 8'd60,
   parameter logic [23:0] RETRY_CLKS   = 24'd6000000,
   parameter logic [2:0]  MAX_RETRY    = 3'd4,
   parameter logic [9:0]  STABLE_SYMS  = 10'd256,
   parameter logic [23:0] BLINK_DIV    = 24'd6000000
) (
   input  logic       i_clk,
   input  logic       i_res_n,
   input  logic       i_sfp_tx_flt,
   input  logic       i_link_en,
   input  logic       i_fault_clr,
   input  logic       i_sym_strobe,
   output logic       o_sfp_tx_dis_n,
   output logic       o_drv_en,
   output logic       o_comma_only,
   output logic       o_payload_en,
   output logic [1:0] o_tx_led,
   output logic [2:0] o_state,
   output logic [2:0] o_retry_cnt
);

   typedef enum logic [2:0] {
      ST_OFF      = 3'd0,
      ST_LASER_ON = 3'd1,
      ST_TRAIN    = 3'd2,
      ST_RUN      = 3'd3,
      ST_FAULT    = 3'd4,
      ST_LOCKOUT  = 3'd5
   } state_t;

   state_t      state, nxt_state;
   logic        flt_meta, flt_s;
   logic [7:0]  deb_cnt;
   logic        flt_det;
   logic [23:0] tmr, tmr_nxt;
   logic [2:0]  retry_cnt, retry_nxt;
   logic        drv_en_q;
   logic [1:0]  led_nxt;
   logic        blink;

   always_ff @(posedge i_clk or negedge i_res_n) begin
      if (!i_res_n) begin
         flt_meta <= 1'b0;
         flt_s    <= 1'b0;
         deb_cnt  <= 8'd0;
      end else begin
         flt_meta <= i_sfp_tx_flt;
         flt_s    <= flt_meta;
         if (!flt_s)
            deb_cnt <= 8'd0;
         else if (deb_cnt != FLT_DEBOUNCE)
            deb_cnt <= deb_cnt + 8'd1;
      end
   end

   assign flt_det = (deb_cnt == FLT_DEBOUNCE);

`ifdef SFP_TX_LINK_CTRL_LED_BLINK_EN
   logic [23:0] blink_cnt;

   always_ff @(posedge i_clk or negedge i_res_n) begin
      if (!i_res_n) begin
         blink_cnt <= 24'd0;
         blink     <= 1'b0;
      end else if (blink_cnt == 24'd0) begin
         blink_cnt <= BLINK_DIV - 24'd1;
         blink     <= ~blink;
      end else begin
         blink_cnt <= blink_cnt - 24'd1;
      end
   end
`else
   // BLINK_DIV only matters when blinking is compiled in.
   logic unused_blink_div;
   assign unused_blink_div = ^BLINK_DIV;
   assign blink = 1'b0;
`endif

   // Timers are down-counters reloaded on every state change; terminal count is 0,
   // except RUN where reaching 0 means "stable, stop counting".
   always_comb begin
      nxt_state = state;
      tmr_nxt   = tmr;
      retry_nxt = retry_cnt;
      if (state == ST_LOCKOUT) begin
         if (i_fault_clr) begin
            nxt_state = ST_OFF;
            retry_nxt = 3'd0;
         end
      end else if (!i_link_en) begin
         nxt_state = ST_OFF;
      end else if (flt_det && (state inside {ST_LASER_ON, ST_TRAIN, ST_RUN})) begin
         nxt_state = (({1'b0, retry_cnt} + 4'd1) == {1'b0, MAX_RETRY}) ? ST_LOCKOUT : ST_FAULT;
         retry_nxt = (retry_cnt == 3'd7) ? 3'd7 : retry_cnt + 3'd1;
      end else begin
         case (state)
            ST_OFF: begin
               if (!flt_s) nxt_state = ST_LASER_ON;
            end
            ST_LASER_ON: begin
               if (tmr == 24'd0) nxt_state = ST_TRAIN;
               else              tmr_nxt   = tmr - 24'd1;
            end
            ST_TRAIN: begin
               if (i_sym_strobe) begin
                  if (tmr == 24'd0) nxt_state = ST_RUN;
                  else              tmr_nxt   = tmr - 24'd1;
               end
            end
            ST_RUN: begin
               if (i_sym_strobe && (tmr != 24'd0)) begin
                  tmr_nxt = tmr - 24'd1;
                  if (tmr == 24'd1) retry_nxt = 3'd0;
               end
            end
            ST_FAULT: begin
               if (tmr == 24'd0) begin
                  if (!flt_s) nxt_state = ST_LASER_ON;
                  else        tmr_nxt   = RETRY_CLKS - 24'd1;
               end else begin
                  tmr_nxt = tmr - 24'd1;
               end
            end
            default: ;
         endcase
      end

      if (nxt_state != state) begin
         case (nxt_state)
            ST_LASER_ON: tmr_nxt = 24'(STARTUP_CLKS) - 24'd1;
            ST_TRAIN:    tmr_nxt = 24'(TRAIN_SYMS) - 24'd1;
            ST_RUN:      tmr_nxt = 24'(STABLE_SYMS);
            ST_FAULT:    tmr_nxt = RETRY_CLKS - 24'd1;
            default:     tmr_nxt = 24'd0;
         endcase
      end

      case (nxt_state)
         ST_LASER_ON: led_nxt = 2'b11;
`ifdef SFP_TX_LINK_CTRL_LED_BLINK_EN
         ST_TRAIN:    led_nxt = {blink, 1'b0};
         ST_LOCKOUT:  led_nxt = {1'b0, blink};
`else
         ST_TRAIN:    led_nxt = 2'b11;
         ST_LOCKOUT:  led_nxt = 2'b01;
`endif
         ST_RUN:      led_nxt = 2'b10;
         ST_FAULT:    led_nxt = 2'b01;
         default:     led_nxt = 2'b00;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_res_n) begin
      if (!i_res_n) begin
         state          <= ST_OFF;
         tmr            <= 24'd0;
         retry_cnt      <= 3'd0;
         o_sfp_tx_dis_n <= 1'b0;
         o_comma_only   <= 1'b0;
         o_payload_en   <= 1'b0;
         drv_en_q       <= 1'b0;
         o_tx_led       <= 2'b00;
      end else begin
         state          <= nxt_state;
         tmr            <= tmr_nxt;
         retry_cnt      <= retry_nxt;
         o_sfp_tx_dis_n <= (nxt_state inside {ST_LASER_ON, ST_TRAIN, ST_RUN});
         o_comma_only   <= (nxt_state == ST_TRAIN);
         o_payload_en   <= (nxt_state == ST_RUN);
         drv_en_q       <= (nxt_state inside {ST_TRAIN, ST_RUN});
         o_tx_led       <= led_nxt;
      end
   end

   // Driver cut follows the synced fault directly, ahead of the debounce.
   assign o_drv_en    = drv_en_q & ~flt_s;
   assign o_state     = state;
   assign o_retry_cnt = retry_cnt;

endmodule

// File: tb/tb_sfp_tx_link_ctrl.sv
// Bench for sfp_tx_link_ctrl: cycle model compared every clock plus directed literal checks.
module tb_sfp_tx_link_ctrl;

   localparam int STARTUP = 10;
   localparam int TRAINS  = 4;
   localparam int DEB     = 3;
   localparam int RETRY   = 20;
   localparam int MAXR    = 2;
   localparam int STABLE  = 8;

   logic       i_clk, i_res_n, i_sfp_tx_flt, i_link_en, i_fault_clr, i_sym_strobe;
   logic       o_sfp_tx_dis_n, o_drv_en, o_comma_only, o_payload_en;
   logic [1:0] o_tx_led;
   logic [2:0] o_state, o_retry_cnt;

   int checks = 0;
   int failures = 0;

   sfp_tx_link_ctrl #(
      .STARTUP_CLKS(16'd10), .TRAIN_SYMS(10'd4), .FLT_DEBOUNCE(8'd3),
      .RETRY_CLKS(24'd20), .MAX_RETRY(3'd2), .STABLE_SYMS(10'd8), .BLINK_DIV(24'd50)
   ) dut (
      .i_clk(i_clk), .i_res_n(i_res_n), .i_sfp_tx_flt(i_sfp_tx_flt),
      .i_link_en(i_link_en), .i_fault_clr(i_fault_clr), .i_sym_strobe(i_sym_strobe),
      .o_sfp_tx_dis_n(o_sfp_tx_dis_n), .o_drv_en(o_drv_en), .o_comma_only(o_comma_only),
      .o_payload_en(o_payload_en), .o_tx_led(o_tx_led), .o_state(o_state),
      .o_retry_cnt(o_retry_cnt)
   );

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   initial begin
      int scnt;
      scnt = 0;
      i_sym_strobe = 1'b0;
      forever begin
         @(posedge i_clk);
         #1;
         i_sym_strobe = (scnt == 29);
         scnt = (scnt + 1) % 30;
      end
   end

   // Behavioural model: elapsed clocks / counted strobes since entering a phase.
   int m_state = 0, m_el = 0, m_stb = 0, m_retry = 0, m_s1 = 0, m_s2 = 0, m_run = 0;

   initial begin
      forever begin
         @(posedge i_clk);
         if (i_res_n) begin
            int ns;
            bit fs, det;
            fs  = (m_s2 != 0);
            det = (m_run >= DEB);
            ns  = m_state;
            if (m_state == 5) begin
               if (i_fault_clr) begin ns = 0; m_retry = 0; end
            end else if (!i_link_en) begin
               ns = 0;
            end else if (det && m_state >= 1 && m_state <= 3) begin
               ns = (m_retry + 1 == MAXR) ? 5 : 4;
               m_retry = (m_retry < 7) ? m_retry + 1 : 7;
            end else begin
               case (m_state)
                  0: if (!fs) ns = 1;
                  1: begin m_el++; if (m_el == STARTUP) ns = 2; end
                  2: if (i_sym_strobe) begin m_stb++; if (m_stb == TRAINS) ns = 3; end
                  3: if (i_sym_strobe && m_stb < STABLE) begin
                        m_stb++;
                        if (m_stb == STABLE) m_retry = 0;
                     end
                  4: begin
                        m_el++;
                        if (m_el == RETRY) begin
                           if (!fs) ns = 1;
                           else m_el = 0;
                        end
                     end
                  default: ;
               endcase
            end
            if (ns != m_state) begin m_el = 0; m_stb = 0; end
            m_state = ns;
            m_run = (m_s2 != 0) ? ((m_run < DEB) ? m_run + 1 : DEB) : 0;
            m_s2 = m_s1;
            m_s1 = int'(i_sfp_tx_flt);
         end
      end
   end

   initial begin
      forever begin
         @(negedge i_clk);
         if (i_res_n) begin
            logic [11:0] exp_v, got_v;
            logic [1:0]  eled;
            case (m_state)
               1, 2:    eled = 2'b11;
               3:       eled = 2'b10;
               4, 5:    eled = 2'b01;
               default: eled = 2'b00;
            endcase
            exp_v = {3'(m_state), 3'(m_retry), (m_state >= 1 && m_state <= 3),
                     ((m_state == 2 || m_state == 3) && m_s2 == 0),
                     (m_state == 2), (m_state == 3), eled};
            got_v = {o_state, o_retry_cnt, o_sfp_tx_dis_n, o_drv_en, o_comma_only,
                     o_payload_en, o_tx_led};
            checks++;
            if (got_v !== exp_v) begin
               failures++;
               $display("FAIL model_cmp t=%0t got {st,rt,dis_n,drv,comma,pay,led}=%03h expected %03h",
                        $time, got_v, exp_v);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_for(input string name, input logic [2:0] s, input int max);
      int n;
      n = 0;
      @(negedge i_clk);
      while (o_state != s && n < max) begin
         n++;
         @(negedge i_clk);
      end
      chk(name, o_state, s);
   endtask

   // Starts on a negedge in state s; returns on the first negedge outside it.
   task automatic dwell(input logic [2:0] s, input int max, output int n, output int nstb);
      n = 0;
      nstb = 0;
      while (o_state == s && n < max) begin
         n++;
         if (i_sym_strobe) nstb++;
         @(negedge i_clk);
      end
   endtask

   task automatic apply_fault(input int clks);
      @(posedge i_clk);
      #1 i_sfp_tx_flt = 1'b1;
      repeat (clks) @(posedge i_clk);
      #1 i_sfp_tx_flt = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n, nstb;
      i_res_n = 1'b0;
      i_sfp_tx_flt = 1'b0;
      i_link_en = 1'b0;
      i_fault_clr = 1'b0;
      repeat (3) @(posedge i_clk);
      #1 i_res_n = 1'b1;
      @(negedge i_clk);
      chk("reset_outputs", {o_state, o_retry_cnt, o_sfp_tx_dis_n, o_drv_en, o_comma_only,
                            o_payload_en, o_tx_led}, 32'h0);

      // Bring-up
      @(posedge i_clk);
      #1 i_link_en = 1'b1;
      wait_for("enter_laser_on", 3'd1, 5);
      dwell(3'd1, 100, n, nstb);
      chk("laser_on_clocks", n, 10);
      chk("train_comma", {o_state, o_comma_only}, {3'd2, 1'b1});
      dwell(3'd2, 500, n, nstb);
      chk("train_strobes", nstb, 4);
      chk("run_outputs", {o_state, o_payload_en, o_comma_only, o_tx_led}, {3'd3, 1'b1, 1'b0, 2'b10});

      // Short glitch: driver drops, no fault taken
      apply_fault(2);
      @(negedge i_clk);
      chk("glitch_drv_drop", {o_state, o_drv_en}, {3'd3, 1'b0});
      repeat (6) @(negedge i_clk);
      chk("glitch_drv_back", {o_state, o_drv_en}, {3'd3, 1'b1});

      // Debounced fault, timed retry
      apply_fault(5);
      wait_for("enter_fault", 3'd4, 20);
      chk("fault_outputs", {o_sfp_tx_dis_n, o_retry_cnt, o_tx_led}, {1'b0, 3'd1, 2'b01});
      dwell(3'd4, 100, n, nstb);
      chk("fault_clocks", n, 20);
      chk("retry_to_laser_on", o_state, 3'd1);

      // Second fault before stable -> lockout
      wait_for("run_again", 3'd3, 1000);
      apply_fault(5);
      wait_for("enter_lockout", 3'd5, 20);
      chk("lockout_retry", o_retry_cnt, 3'd2);
      @(posedge i_clk);
      #1 i_link_en = 1'b0;
      repeat (3) @(posedge i_clk);
      #1 i_link_en = 1'b1;
      repeat (3) @(negedge i_clk);
      chk("lockout_holds", {o_state, o_tx_led}, {3'd5, 2'b01});
      @(posedge i_clk);
      #1 i_fault_clr = 1'b1;
      @(posedge i_clk);
      #1 i_fault_clr = 1'b0;
      @(negedge i_clk);
      chk("clear_lockout", {o_state, o_retry_cnt}, {3'd0, 3'd0});

      // One fault, then link drop coinciding with a new debounced fault in TRAIN
      wait_for("run_third", 3'd3, 1000);
      apply_fault(5);
      wait_for("enter_fault2", 3'd4, 20);
      chk("fault2_retry", o_retry_cnt, 3'd1);
      wait_for("train_again", 3'd2, 200);
      @(posedge i_clk);
      #1 i_sfp_tx_flt = 1'b1;
      repeat (5) @(posedge i_clk);
      #1 begin i_sfp_tx_flt = 1'b0; i_link_en = 1'b0; end
      @(posedge i_clk);
      @(negedge i_clk);
      chk("linkdrop_beats_fault", {o_state, o_retry_cnt}, {3'd0, 3'd1});
      repeat (3) @(posedge i_clk);
      #1 i_link_en = 1'b1;

      // Stable run clears retry count after 8 strobes
      wait_for("run_fourth", 3'd3, 1000);
      chk("run_entry_retry", o_retry_cnt, 3'd1);
      n = 0;
      nstb = 0;
      while (o_retry_cnt != 3'd0 && n < 500) begin
         n++;
         if (i_sym_strobe) nstb++;
         @(negedge i_clk);
      end
      chk("stable_strobes", nstb, 8);
      chk("stable_state", {o_state, o_retry_cnt}, {3'd3, 3'd0});

      repeat (5) @(negedge i_clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
